ocd_vjtag_scan_master: RTL

//  Host-side initiator for the Nios II OCI virtual-JTAG debug interface.

---
 rtl/ocd_vjtag_scan_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ocd_vjtag_scan_master.sv
// Host-side virtual-JTAG scan master: turns an {IR, DR} command into the
// vji_* strobe/TCK sequence (optional UIR, CDR, DR_W x SDR, UDR) and returns the captured TDO bits.
module ocd_vjtag_scan_master #(
  parameter int unsigned IR_W    = 2,
  parameter int unsigned DR_W    = 38,
  parameter int unsigned TCK_DIV = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int unsigned PH_W = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam int unsigned BC_W = (DR_W > 1) ? $clog2(DR_W) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_DIV - 1);
  localparam logic [PH_W-1:0] PH_CAP  = PH_W'(TCK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(TCK_DIV);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [DR_W-1:0]   dr_q, dr_d;
  logic [DR_W-1:0]   rsp_q, rsp_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              ir_known_q, ir_known_d;
  logic              period_end;
  logic              busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      dr_q       <= '0;
      rsp_q      <= '0;
      ir_q       <= '0;
      ir_known_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      dr_q       <= dr_d;
      rsp_q      <= rsp_d;
      ir_q       <= ir_d;
      ir_known_q <= ir_known_d;
    end
  end

  assign period_end = (phase_q == PH_LAST);
  assign busy       = (state_q != S_IDLE) && (state_q != S_RSP);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    dr_d       = dr_q;
    rsp_d      = rsp_q;
    ir_d       = ir_q;
    ir_known_d = ir_known_q;
    if (busy) begin
      phase_d = period_end ? '0 : phase_q + PH_W'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (cmd_valid) begin
          dr_d = cmd_dr;
          // ir_in is loaded on acceptance so it is already valid in UIR's phase 0
          ir_d = cmd_ir;
          state_d = (!ir_known_q || (cmd_ir != ir_q)) ? S_UIR : S_CDR;
        end
      end
      S_UIR: begin
        if (period_end) begin
          ir_known_d = 1'b1;
          state_d    = S_CDR;
        end
      end
      S_CDR: begin
        if (period_end) begin
          bit_d   = '0;
          state_d = S_SDR;
        end
      end
      S_SDR: begin
        // TDO is sampled on the edge where TCK rises
        if (phase_q == PH_CAP) begin
          rsp_d = {vji_tdo, rsp_q[DR_W-1:1]};
        end
        if (period_end) begin
          dr_d = dr_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = S_UDR;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end
      S_UDR: begin
        if (period_end) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RSP);
    vji_rti   = (state_q == S_IDLE) || (state_q == S_RSP);
    vji_uir   = (state_q == S_UIR);
    vji_cdr   = (state_q == S_CDR);
    vji_sdr   = (state_q == S_SDR);
    vji_udr   = (state_q == S_UDR);
    vji_tck   = busy && (phase_q >= PH_HI);
    vji_tdi   = (state_q == S_SDR) && dr_q[0];
    vji_ir_in = ir_q;
    rsp_dr    = rsp_q;
  end

endmodule
